// File: rtl/secuenciador_pkg.sv
// Shared opcodes, state encoding and PC step for the multi-cycle sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package secuenciador_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/secuenciador_dp_pc_unit.sv
// Program counter: sequential step or PC-relative branch, updated on pc_load.
// Latency: new PC visible one cycle after pc_load.
// Backpressure: none; holds value whenever pc_load is low.
module pc_unit
    import secuenciador_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic        take_branch,
    input  logic [15:0] imm16,
    output logic [31:0] pc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_seq;
    logic [31:0] br_off;

    always_comb begin
        pc_seq = pc_q + PC_STEP;
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        pc_d   = pc_q;
        if (pc_load) begin
            pc_d = take_branch ? (pc_seq + br_off) : pc_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/secuenciador_dp.sv
// Multi-cycle fetch/decode/execute sequencer driving the R/LW/SW/BEQ datapath.
// Latency: BEQ/NOP 3, R/SW 4, LW 5 cycles plus one per fetch wait cycle.
// Backpressure: stalls in FETCH holding im_req/im_addr until im_ack.
module secuenciador_dp
    import secuenciador_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    input  logic        zf,
    output logic        im_req,
    output logic [31:0] im_addr,
    output logic [31:0] instruccion,
    output logic        reg_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;
    logic        take_branch;
    logic [5:0]  opcode;
    logic [31:0] pc;

    assign opcode = ir_q[31:26];

    pc_unit #(
        .RESET_PC    (RESET_PC)
    ) u_pc_unit (
        .clk         (clk),
        .rst         (rst),
        .pc_load     (retire),
        .take_branch (take_branch),
        .imm16       (ir_q[15:0]),
        .pc          (pc)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        retire      = 1'b0;
        take_branch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (im_ack) begin
                    ir_d    = im_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // NOPs also pass through EXEC so their latency matches BEQ.
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        retire      = 1'b1;
                        take_branch = zf;
                    end
                    default:      retire = 1'b1;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LW) state_d = S_WB;
                else                 retire  = 1'b1;
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign im_req      = (state_q == S_FETCH);
    assign im_addr     = pc;
    assign instruccion = ir_q;
    assign reg_en      = (state_q == S_WB);
    assign mem_rd      = (state_q == S_MEM) && (opcode == OP_LW);
    assign mem_wr      = (state_q == S_MEM) && (opcode == OP_SW);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_secuenciador_dp.sv
// Randomized self-checking bench for secuenciador_dp against an instruction-level model.
module tb_secuenciador_dp;

    localparam logic [5:0]  T_RTYPE = 6'b000000;
    localparam logic [5:0]  T_LW    = 6'b100011;
    localparam logic [5:0]  T_SW    = 6'b101011;
    localparam logic [5:0]  T_BEQ   = 6'b000100;
    localparam logic [5:0]  T_HALT  = 6'b111111;
    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] W_NOP   = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        im_ack;
    logic [31:0] im_data;
    logic        zf;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] instruccion;
    logic        reg_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        halted;
    logic [31:0] retired;

    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    secuenciador_dp #(.RESET_PC(T_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .im_ack      (im_ack),
        .im_data     (im_data),
        .zf          (zf),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .instruccion (instruccion),
        .reg_en      (reg_en),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic hard_reset();
        rst = 1'b1; start = 1'b0; im_ack = 1'b0; im_data = 32'd0; zf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = T_RESET_PC;
        m_ret = 32'd0;
        @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from its first FETCH cycle to the next FETCH (or HALT).
    task automatic run_instr(input logic [31:0] w, input int dly, input logic zfv);
        logic [5:0]  op;
        logic [2:0]  exp_q[$];
        logic [31:0] off;
        op = w[31:26];
        exp_q.push_back(3'b000);
        if (op != T_HALT) exp_q.push_back(3'b000);
        if (op == T_LW) begin
            exp_q.push_back(3'b010);
            exp_q.push_back(3'b100);
        end else if (op == T_SW) begin
            exp_q.push_back(3'b001);
        end else if (op == T_RTYPE) begin
            exp_q.push_back(3'b100);
        end

        for (int i = 0; i <= dly; i++) begin
            ncmp++;
            if (im_req !== 1'b1 || im_addr !== m_pc || busy !== 1'b1) begin
                nerr++;
                $display("FAIL fetch[%0d] w=%h: im_req=%b im_addr=%h busy=%b, required 1 %h 1",
                         i, w, im_req, im_addr, busy, m_pc);
            end
            im_ack  = (i == dly);
            im_data = (i == dly) ? w : $urandom;
            zf      = 1'($urandom);
            start   = 1'($urandom);
            @(negedge clk);
        end

        foreach (exp_q[k]) begin
            ncmp++;
            if ({reg_en, mem_rd, mem_wr} !== exp_q[k] || instruccion !== w || im_req !== 1'b0 ||
                busy !== 1'b1 || halted !== 1'b0 || retired !== m_ret) begin
                nerr++;
                $display("FAIL exec[%0d] w=%h: strobes=%b ir=%h req=%b busy=%b halted=%b retired=%h, required %b %h 0 1 0 %h",
                         k, w, {reg_en, mem_rd, mem_wr}, instruccion, im_req, busy, halted, retired,
                         exp_q[k], w, m_ret);
            end
            im_ack  = 1'($urandom);
            im_data = $urandom;
            start   = 1'($urandom);
            zf      = (op == T_BEQ && k == 1) ? zfv : 1'($urandom);
            @(negedge clk);
        end
        start  = 1'b0;
        im_ack = 1'b0;

        if (op == T_HALT) begin
            ncmp++;
            if (halted !== 1'b1 || busy !== 1'b0 || im_req !== 1'b0 || retired !== m_ret) begin
                nerr++;
                $display("FAIL halt_entry: halted=%b busy=%b req=%b retired=%h, required 1 0 0 %h",
                         halted, busy, im_req, retired, m_ret);
            end
        end else begin
            off   = (op == T_BEQ && zfv) ? 32'(int'($signed(w[15:0])) * 4) : 32'd0;
            m_pc  = m_pc + 32'd4 + off;
            m_ret = m_ret + 32'd1;
            ncmp++;
            if (im_req !== 1'b1 || im_addr !== m_pc || retired !== m_ret || instruccion !== w) begin
                nerr++;
                $display("FAIL retire w=%h: req=%b im_addr=%h retired=%h ir=%h, required 1 %h %h %h",
                         w, im_req, im_addr, retired, instruccion, m_pc, m_ret, w);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; im_ack = 1'b0; im_data = 32'd0; zf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ncmp++;
        if ({im_req, reg_en, mem_rd, mem_wr, busy, halted} !== 6'b0 || instruccion !== 32'd0 ||
            retired !== 32'd0 || im_addr !== T_RESET_PC) begin
            nerr++;
            $display("FAIL reset_values: ctl=%b ir=%h retired=%h im_addr=%h, required 000000 0 0 %h",
                     {im_req, reg_en, mem_rd, mem_wr, busy, halted}, instruccion, retired, im_addr, T_RESET_PC);
        end
        rst = 1'b0;
        m_pc = T_RESET_PC;
        m_ret = 32'd0;
        im_ack = 1'b1; im_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        im_ack = 1'b0;
        ncmp++;
        if (busy !== 1'b0 || im_req !== 1'b0 || instruccion !== 32'd0) begin
            nerr++;
            $display("FAIL idle_hold: busy=%b req=%b ir=%h, required 0 0 0", busy, im_req, instruccion);
        end
    endtask

    task automatic test_rtype();
        hard_reset();
        kick();
        run_instr(32'h0022_1820, 0, 1'b0);
    endtask

    task automatic test_lw_delayed();
        hard_reset();
        kick();
        run_instr(32'h8C41_0008, 3, 1'b0);
        run_instr(32'hAC41_0004, 1, 1'b0);
    endtask

    task automatic test_beq();
        hard_reset();
        kick();
        run_instr(W_NOP, 0, 1'b0);
        run_instr(32'h0022_1820, 0, 1'b0);
        run_instr(32'h1000_FFFF, 0, 1'b1);
        run_instr(32'h1000_FFFF, 2, 1'b0);
    endtask

    task automatic test_halt();
        hard_reset();
        kick();
        run_instr(32'h0022_1820, 0, 1'b0);
        run_instr(32'hFC00_0000, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            start  = (i % 2 == 0);
            im_ack = 1'($urandom);
            @(negedge clk);
            ncmp++;
            if (halted !== 1'b1 || busy !== 1'b0 || im_req !== 1'b0 || retired !== m_ret) begin
                nerr++;
                $display("FAIL halt_absorb[%0d]: halted=%b busy=%b req=%b retired=%h, required 1 0 0 %h",
                         i, halted, busy, im_req, retired, m_ret);
            end
        end
        start = 1'b0; im_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if (halted !== 1'b0 || busy !== 1'b0 || im_addr !== T_RESET_PC || retired !== 32'd0) begin
            nerr++;
            $display("FAIL halt_reset: halted=%b busy=%b im_addr=%h retired=%h, required 0 0 %h 0",
                     halted, busy, im_addr, retired, T_RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc = T_RESET_PC;
        m_ret = 32'd0;
        @(negedge clk);
        kick();
        run_instr(W_NOP, 0, 1'b0);
    endtask

    task automatic test_rst_mid_fetch();
        hard_reset();
        kick();
        run_instr(W_NOP, 0, 1'b0);
        im_ack = 1'b0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (im_req !== 1'b1 || im_addr !== m_pc) begin
            nerr++;
            $display("FAIL fetch_wait: req=%b im_addr=%h, required 1 %h", im_req, im_addr, m_pc);
        end
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if (im_req !== 1'b0 || busy !== 1'b0 || im_addr !== T_RESET_PC || retired !== 32'd0) begin
            nerr++;
            $display("FAIL rst_mid_fetch: req=%b busy=%b im_addr=%h retired=%h, required 0 0 %h 0",
                     im_req, busy, im_addr, retired, T_RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc = T_RESET_PC;
        m_ret = 32'd0;
    endtask

    task automatic test_rst_mid_mem();
        hard_reset();
        kick();
        im_ack = 1'b1; im_data = 32'hAC41_0008;
        @(negedge clk);
        im_ack = 1'b0; im_data = 32'd0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || reg_en !== 1'b0) begin
            nerr++;
            $display("FAIL sw_mem: mem_wr=%b mem_rd=%b reg_en=%b, required 1 0 0", mem_wr, mem_rd, reg_en);
        end
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || retired !== 32'd0 || im_addr !== T_RESET_PC) begin
            nerr++;
            $display("FAIL rst_mid_mem: mem_wr=%b busy=%b retired=%h im_addr=%h, required 0 0 0 %h",
                     mem_wr, busy, retired, im_addr, T_RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc = T_RESET_PC;
        m_ret = 32'd0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (retired !== 32'd0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL post_rst_mem: retired=%h mem_wr=%b busy=%b, required 0 0 0", retired, mem_wr, busy);
        end
    endtask

    task automatic test_pc_wrap();
        hard_reset();
        kick();
        run_instr(32'h1000_FFFE, 0, 1'b1);
        run_instr(W_NOP, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] w;
        hard_reset();
        kick();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       op = T_RTYPE;
                1:       op = T_LW;
                2:       op = T_SW;
                3:       op = T_BEQ;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ || op == T_HALT)
                        op = 6'b001000;
                end
            endcase
            w = {op, 26'($urandom)};
            run_instr(w, int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_delayed();
        test_beq();
        test_halt();
        test_rst_mid_fetch();
        test_rst_mid_mem();
        test_pc_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
